// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and command sequencer placing two fabric clients on one
// 2048 x 32 RAM block: registered strobes, tagged read return, idle power-down.
module ram_port_arbiter #(
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [10:0] addr_a,
  input  logic [10:0] addr_b,
  input  logic [31:0] wdata_a,
  input  logic [31:0] wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [31:0] rdata,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [10:0] ram_raddr,
  output logic [10:0] ram_waddr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        ram_powerdn
);

  localparam int unsigned TAG_DEPTH = RD_LATENCY + 1;
  localparam logic [7:0]  IDLE_M1   = 8'(IDLE_CYCLES - 1);
  localparam bit          PD_ENABLE = (IDLE_CYCLES != 0);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  owner_e      last_q, last_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [10:0] raddr_q, raddr_d;
  logic [10:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  tag_t        tag_q [TAG_DEPTH];
  tag_t        tag_d [TAG_DEPTH];
  logic [7:0]  cnt_q, cnt_d;
  logic        pd_q, pd_d;

  logic        pick_b;
  logic        gnt_en;
  logic        any_gnt;
  logic        any_req;
  logic        pipe_busy;
  logic        sel_we;
  logic [10:0] sel_addr;
  logic [31:0] sel_wdata;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    if (req_a && req_b) begin
      pick_b = (last_q == OWN_A);
    end else begin
      pick_b = req_b;
    end
  end

  assign gnt_en    = !rst && !pd_q;
  assign gnt_a     = gnt_en && req_a && !pick_b;
  assign gnt_b     = gnt_en && req_b && pick_b;
  assign any_gnt   = gnt_a || gnt_b;
  assign any_req   = req_a || req_b;
  assign sel_we    = pick_b ? we_b    : we_a;
  assign sel_addr  = pick_b ? addr_b  : addr_a;
  assign sel_wdata = pick_b ? wdata_b : wdata_a;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    last_d  = last_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (any_gnt) begin
      last_d = pick_b ? OWN_B : OWN_A;
      if (sel_we) begin
        wen_d   = 1'b1;
        waddr_d = sel_addr;
        wdata_d = sel_wdata;
      end else begin
        ren_d   = 1'b1;
        raddr_d = sel_addr;
      end
    end
  end

  always_comb begin
    tag_d[0].valid = any_gnt && !sel_we;
    tag_d[0].owner = pick_b ? OWN_B : OWN_A;
    for (int i = 1; i < TAG_DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // The counter saturates so a long idle stretch cannot wrap and re-trigger.
  always_comb begin
    cnt_d = cnt_q;
    pd_d  = pd_q;
    if (any_req || pipe_busy) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (pd_q && any_req) begin
      pd_d = 1'b0;
    end else if (PD_ENABLE && !any_req && !pipe_busy && cnt_q == IDLE_M1) begin
      pd_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= OWN_B;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      pd_q    <= 1'b0;
      // NOTE: the tag pipe is control state, not storage, so it is reset;
      // that is what drops reads in flight when reset hits mid-operation.
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      last_q  <= last_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      pd_q    <= pd_d;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign ram_ren     = ren_q;
  assign ram_wen     = wen_q;
  assign ram_raddr   = raddr_q;
  assign ram_waddr   = waddr_q;
  assign ram_wdata   = wdata_q;
  assign ram_powerdn = pd_q;

  // The oldest tag lines up with RDATA from the read it was loaded for.
  assign rvalid_a = tag_q[RD_LATENCY].valid && (tag_q[RD_LATENCY].owner == OWN_A);
  assign rvalid_b = tag_q[RD_LATENCY].valid && (tag_q[RD_LATENCY].owner == OWN_B);
  assign rdata    = ram_rdata;

endmodule
